// File: rtl/sample_rle_if.sv
// Stream bundle around the run-length compressor: the incoming sample
// stream (s_*) and the outgoing {count, value} word stream (m_*).
// The slave modport is the compressor's view; master is the environment's.
interface sample_rle_if #(
    parameter int size  = 32,
    parameter int cnt_w = 16
) ();
    logic [size-1:0]       s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic [cnt_w+size-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/sample_rle.sv
// Run-length compressor for the captured sample stream. Consecutive equal
// samples collapse into one {count, value} word (count in the MSBs); a flush
// request emits the pending run as the last word of a packet.
// Optional build macro: RLE_STATS_EN adds the stat_in/stat_out counters;
// without it both outputs are tied to zero.
module sample_rle #(
    parameter int size  = 32,
    parameter int cnt_w = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    sample_rle_if.slave bus,
    output logic        flush_done,
    output logic [31:0] stat_in,
    output logic [31:0] stat_out
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [cnt_w-1:0] CNT_MAX = '1;
    localparam logic [cnt_w-1:0] CNT_ONE = {{(cnt_w-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [size-1:0]       run_val_q, run_val_d;
    logic [cnt_w-1:0]      run_cnt_q, run_cnt_d;
    logic                  run_pend_q, run_pend_d;
    logic                  flush_done_q, flush_done_d;
    logic [cnt_w+size-1:0] m_tdata_q;
    logic                  m_tvalid_q;
    logic                  m_tlast_q, m_tlast_d;
    logic                  load_slot;
    logic                  slot_free;
    logic                  s_ready;
    logic                  accept;
    logic                  merge;

    // A run that has reached the top count must be closed, never wrapped.
    function automatic logic cnt_saturated(input logic [cnt_w-1:0] cnt);
        return cnt == CNT_MAX;
    endfunction

    // Input is taken only when a terminated run could land in the slot and
    // no flush is in progress, so merges also stall behind a blocked slot.
    assign slot_free = !m_tvalid_q || bus.m_tready;
    assign s_ready   = !reset && slot_free && (state_q != FLUSH);
    assign accept    = bus.s_tvalid && s_ready;
    assign merge     = enable && (bus.s_tdata == run_val_q) && !cnt_saturated(run_cnt_q);

    // Next-state, run bookkeeping and slot-load decisions.
    always_comb begin
        state_d      = state_q;
        run_val_d    = run_val_q;
        run_cnt_d    = run_cnt_q;
        run_pend_d   = run_pend_q;
        load_slot    = 1'b0;
        m_tlast_d    = 1'b0;
        flush_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    run_val_d  = bus.s_tdata;
                    run_cnt_d  = CNT_ONE;
                    run_pend_d = 1'b1;
                    state_d    = RUN;
                end
                // A sample arriving with the flush is absorbed first.
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            RUN: begin
                if (accept) begin
                    if (merge) begin
                        run_cnt_d = run_cnt_q + CNT_ONE;
                    end else begin
                        load_slot = 1'b1;
                        run_val_d = bus.s_tdata;
                        run_cnt_d = CNT_ONE;
                    end
                end
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Further flush requests are ignored while one is pending.
                if (!run_pend_q) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end else if (slot_free) begin
                    load_slot    = 1'b1;
                    m_tlast_d    = 1'b1;
                    run_pend_d   = 1'b0;
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers: FSM state, run count/pending flag and flush pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            run_cnt_q    <= '0;
            run_pend_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            run_pend_q   <= run_pend_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Run value is plain data; it is only meaningful while a run is pending.
    always_ff @(posedge clk) begin
        run_val_q <= run_val_d;
    end

    // Output slot: load a closed run, drop valid on handshake, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else if (load_slot) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= {run_cnt_q, run_val_q};
            m_tlast_q  <= m_tlast_d;
        end else if (bus.m_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign bus.s_tready = s_ready;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tlast  = m_tlast_q;
    assign flush_done   = flush_done_q;

`ifdef RLE_STATS_EN
    logic [31:0] stat_in_q;
    logic [31:0] stat_out_q;

    // Traffic counters: accepted samples and delivered words, wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_in_q  <= '0;
            stat_out_q <= '0;
        end else begin
            if (accept) begin
                stat_in_q <= stat_in_q + 32'd1;
            end
            if (m_tvalid_q && bus.m_tready) begin
                stat_out_q <= stat_out_q + 32'd1;
            end
        end
    end

    assign stat_in  = stat_in_q;
    assign stat_out = stat_out_q;
`else
    assign stat_in  = '0;
    assign stat_out = '0;
`endif
endmodule
